// File: rtl/placement_pkg.sv
// Shared definitions for the placement checker: empty marker, record flag bit
// positions and the checker state encoding.
package placement_pkg;

    localparam int EMPTY    = -1;

    localparam int UNPLACED = 0;
    localparam int OOB      = 1;
    localparam int MISMATCH = 2;
    localparam int FLAG_W   = 3;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        N_RD  = 4'd1,
        WAIT  = 4'd2,
        N_CHK = 4'd3,
        N_IDX = 4'd4,
        N_CMP = 4'd5,
        EMIT  = 4'd6,
        G_RD  = 4'd7,
        G_CHK = 4'd8,
        G_CMP = 4'd9,
        FIN   = 4'd10
    } state_t;

endpackage

// File: rtl/placement_checker_if.sv
// Per-node record stream produced by the placement checker (valid/ready).
interface placement_checker_if #(
    parameter int DATA_W = 32
);
    import placement_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_node;
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_y;
    logic [FLAG_W-1:0] out_flags;

    modport master (
        output out_valid, out_node, out_x, out_y, out_flags,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_node, out_x, out_y, out_flags,
        output out_ready
    );

endinterface

// File: rtl/placement_rd_port.sv
// One-read-at-a-time port onto a synchronous RAM: registered re/addr, data
// captured two edges after the request, rd_done high in the cycle before capture.
module placement_rd_port #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [AW-1:0] req_addr,
    output logic          re,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] dout,
    output logic [DW-1:0] data,
    output logic          rd_done
);

    logic pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            re   <= 1'b0;
            addr <= '0;
            pend <= 1'b0;
            data <= '0;
        end else begin
            re   <= req;
            if (req)
                addr <= req_addr;
            pend <= re;
            if (pend)
                data <= dout;
        end
    end

    // rd_done leads the capture edge so the consumer's WAIT exits on it
    assign rd_done = pend;

endmodule

// File: rtl/placement_checker.sv
// Post-placement consistency checker: scans pos_X/pos_Y per node and the grid
// per cell, streams one record per node and reports sticky errors and counters.
module placement_checker
    import placement_pkg::*;
#(
    parameter int GRID_N    = 6,
    parameter int NUM_NODES = 36,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rePX,
    output logic [DATA_W-1:0] addrPX,
    input  logic [DATA_W-1:0] doutPX,
    output logic              rePY,
    output logic [DATA_W-1:0] addrPY,
    input  logic [DATA_W-1:0] doutPY,
    output logic              reGrid,
    output logic [DATA_W-1:0] addrGrid,
    input  logic [DATA_W-1:0] doutGrid,
    placement_checker_if.master rec,
    output logic              err_bounds,
    output logic              err_mismatch,
    output logic              err_orphan,
    output logic [CNT_W-1:0]  placed_cnt,
    output logic [CNT_W-1:0]  unplaced_cnt,
    output logic [CNT_W-1:0]  occupied_cnt,
    output logic [DATA_W-1:0] first_err_node
);

    localparam logic [DATA_W-1:0]        EMPTY_W = DATA_W'(EMPTY);
    localparam logic [DATA_W-1:0]        NN      = DATA_W'(NUM_NODES);
    localparam logic [DATA_W-1:0]        NC      = DATA_W'(GRID_N * GRID_N);
    localparam logic [DATA_W-1:0]        GN      = DATA_W'(GRID_N);
    localparam logic signed [DATA_W-1:0] GMAX    = DATA_W'(GRID_N - 1);

    state_t            state, ret;
    logic [DATA_W-1:0] v, c, aux;

    logic                pos_req, grid_req, pos_re, pos_done, grid_done;
    logic [DATA_W-1:0]   pos_addr, grid_addr, pos_ad;
    logic [2*DATA_W-1:0] pos_data;
    logic [DATA_W-1:0]   grid_data;
    logic [DATA_W-1:0]   px, py, gid;
    logic                xy_unplaced, xy_oob, g_empty, g_oor, err_any;

    assign px      = pos_data[2*DATA_W-1:DATA_W];
    assign py      = pos_data[DATA_W-1:0];
    assign gid     = grid_data;
    assign err_any = err_bounds | err_mismatch | err_orphan;

    always_comb begin
        xy_unplaced = (px == EMPTY_W) && (py == EMPTY_W);
        xy_oob      = px[DATA_W-1] || ($signed(px) > GMAX) ||
                      py[DATA_W-1] || ($signed(py) > GMAX);
        g_empty     = (gid == EMPTY_W);
        g_oor       = gid[DATA_W-1] || (gid >= NN);

        pos_req   = 1'b0;
        pos_addr  = v;
        grid_req  = 1'b0;
        grid_addr = aux;
        case (state)
            N_RD:  pos_req = (v != NN);
            N_IDX: grid_req = 1'b1;
            G_RD: begin
                grid_req  = (c != NC);
                grid_addr = c;
            end
            G_CHK: begin
                pos_req  = !g_empty && !g_oor;
                pos_addr = gid;
            end
            default: ;
        endcase
    end

    placement_rd_port #(.AW(DATA_W), .DW(2*DATA_W)) u_pos_port (
        .clk      (clk),
        .reset    (reset),
        .req      (pos_req),
        .req_addr (pos_addr),
        .re       (pos_re),
        .addr     (pos_ad),
        .dout     ({doutPX, doutPY}),
        .data     (pos_data),
        .rd_done  (pos_done)
    );

    placement_rd_port #(.AW(DATA_W), .DW(DATA_W)) u_grid_port (
        .clk      (clk),
        .reset    (reset),
        .req      (grid_req),
        .req_addr (grid_addr),
        .re       (reGrid),
        .addr     (addrGrid),
        .dout     (doutGrid),
        .data     (grid_data),
        .rd_done  (grid_done)
    );

    assign rePX   = pos_re;
    assign rePY   = pos_re;
    assign addrPX = pos_ad;
    assign addrPY = pos_ad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ret            <= IDLE;
            v              <= '0;
            c              <= '0;
            aux            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            rec.out_valid  <= 1'b0;
            rec.out_node   <= '0;
            rec.out_x      <= '0;
            rec.out_y      <= '0;
            rec.out_flags  <= '0;
            err_bounds     <= 1'b0;
            err_mismatch   <= 1'b0;
            err_orphan     <= 1'b0;
            placed_cnt     <= '0;
            unplaced_cnt   <= '0;
            occupied_cnt   <= '0;
            first_err_node <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy           <= 1'b1;
                    v              <= '0;
                    err_bounds     <= 1'b0;
                    err_mismatch   <= 1'b0;
                    err_orphan     <= 1'b0;
                    placed_cnt     <= '0;
                    unplaced_cnt   <= '0;
                    occupied_cnt   <= '0;
                    first_err_node <= '1;
                    state          <= N_RD;
                end
                N_RD: begin
                    if (v == NN) begin
                        c     <= '0;
                        state <= G_RD;
                    end else begin
                        ret   <= N_CHK;
                        state <= WAIT;
                    end
                end
                WAIT: if (pos_done || grid_done) state <= ret;
                N_CHK: begin
                    // record payload is loaded here; flags/valid follow on the EMIT path
                    rec.out_node  <= v;
                    rec.out_x     <= px;
                    rec.out_y     <= py;
                    rec.out_flags <= '0;
                    if (xy_unplaced) begin
                        rec.out_flags[UNPLACED] <= 1'b1;
                        rec.out_valid           <= 1'b1;
                        unplaced_cnt            <= unplaced_cnt + CNT_W'(1);
                        state                   <= EMIT;
                    end else if (xy_oob) begin
                        rec.out_flags[OOB] <= 1'b1;
                        rec.out_valid      <= 1'b1;
                        err_bounds         <= 1'b1;
                        if (!err_any) first_err_node <= v;
                        state              <= EMIT;
                    end else begin
                        aux   <= px * GN + py;
                        state <= N_IDX;
                    end
                end
                N_IDX: begin
                    ret   <= N_CMP;
                    state <= WAIT;
                end
                N_CMP: begin
                    if (gid != v) begin
                        rec.out_flags[MISMATCH] <= 1'b1;
                        err_mismatch            <= 1'b1;
                        if (!err_any) first_err_node <= v;
                    end else begin
                        placed_cnt <= placed_cnt + CNT_W'(1);
                    end
                    rec.out_valid <= 1'b1;
                    state         <= EMIT;
                end
                EMIT: if (rec.out_ready) begin
                    rec.out_valid <= 1'b0;
                    v             <= v + DATA_W'(1);
                    state         <= N_RD;
                end
                G_RD: begin
                    if (c == NC) begin
                        state <= FIN;
                    end else begin
                        ret   <= G_CHK;
                        state <= WAIT;
                    end
                end
                G_CHK: begin
                    if (g_empty) begin
                        c     <= c + DATA_W'(1);
                        state <= G_RD;
                    end else if (g_oor) begin
                        err_orphan <= 1'b1;
                        if (!err_any) first_err_node <= '1;
                        c          <= c + DATA_W'(1);
                        state      <= G_RD;
                    end else begin
                        occupied_cnt <= occupied_cnt + CNT_W'(1);
                        ret          <= G_CMP;
                        state        <= WAIT;
                    end
                end
                G_CMP: begin
                    if ((px == EMPTY_W) || ((px * GN + py) != c)) begin
                        err_orphan <= 1'b1;
                        if (!err_any) first_err_node <= gid;
                    end
                    c     <= c + DATA_W'(1);
                    state <= G_RD;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/placement_checker.md
Name: placement_checker

Overview:
- Reads back the pos_X, pos_Y and grid RAMs after a placement run, from the consumer side of those memories.
- Checks that every node's recorded coordinate is in range and that its grid cell holds that node's id.
- Checks that every occupied grid cell points back to a node whose recorded position is that cell.
- Streams one (node, x, y, flags) record per node over valid/ready, then raises done with sticky error flags and counters.

Parameters:
- GRID_N, 6, grid side length; cell index = x*GRID_N + y.
- NUM_NODES, 36, nodes scanned (ids 0..NUM_NODES-1).
- DATA_W, 32, width of memory words; -1 (all ones) means "empty/unplaced".
- CNT_W, 16, width of counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a check when idle
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of check
- rePX/rePY  out  1  pos_X/pos_Y read enable (registered)
- addrPX/addrPY  out  DATA_W  node address (registered)
- doutPX/doutPY  in  DATA_W  signed read data
- reGrid  out  1  grid read enable (registered)
- addrGrid  out  DATA_W  cell address (registered)
- doutGrid  in  DATA_W  signed read data
- out_valid  out  1  record valid
- out_ready  in  1  sink accepts
- out_node  out  DATA_W  node id
- out_x, out_y  out  DATA_W  recorded coordinates
- out_flags  out  3  {mismatch, out_of_bounds, unplaced}
- err_bounds, err_mismatch, err_orphan  out  1  sticky error flags
- placed_cnt, unplaced_cnt, occupied_cnt  out  CNT_W  counters
- first_err_node  out  DATA_W  node id of first error; -1 if none

Behaviour:
- Reset values: all outputs 0, except first_err_node = -1. FSM goes to IDLE. Reset mid-operation aborts immediately; no done pulse.
- Memory timing: the block registers re/addr at edge t; the RAM samples at t+1; read data is captured by the block at t+2 (one WAIT state). re is high for exactly one cycle per read. The block never writes.
- IDLE: on start go to N_RD with v=0; clear counters and flags; busy=1. start while busy is ignored.
- N_RD: if v==NUM_NODES go to G_RD with c=0; otherwise read pos_X[v] and pos_Y[v], then WAIT, then N_CHK.
- N_CHK:
  - x==-1 and y==-1: unplaced; unplaced_cnt++; go to EMIT.
  - Otherwise, if x or y is outside [0, GRID_N-1]: out_of_bounds; err_bounds=1; go to EMIT.
  - Otherwise: aux = x*GRID_N + y is registered in N_IDX; read grid[aux]; WAIT; N_CMP.
- N_CMP: if doutGrid != v, set mismatch and err_mismatch=1; else placed_cnt++. Go to EMIT.
- EMIT: out_valid=1 with node/x/y/flags held stable until out_valid&&out_ready. On that handshake: v++, back to N_RD.
  - The handshake may occur in the first EMIT cycle (minimum 1 cycle per record).
  - out_valid never drops without ready.
- G_RD: if c==GRID_N*GRID_N go to FIN; otherwise read grid[c]; WAIT; G_CHK.
- G_CHK:
  - id==-1: c++, back to G_RD.
  - id outside [0, NUM_NODES-1]: err_orphan=1; c++.
  - Otherwise occupied_cnt++; read pos_X[id] and pos_Y[id]; WAIT; G_CMP.
- G_CMP: if x*GRID_N+y != c (or x==-1), err_orphan=1. c++, go to G_RD.
- FIN: done=1 for one cycle, busy=0, return to IDLE. Flags and counters hold until the next start.
- first_err_node: latched on the first error of any type. For grid-phase errors it is the cell's id value (-1 if the id is out of range).
- Arithmetic: coordinates are compared signed. Index products are computed at DATA_W, truncated.
- Consistency invariant for a legal placement: placed_cnt == occupied_cnt and no error flag set.
- NUM_NODES=0: no records emitted; grid phase still runs.

Decomposition:
- Shared package placement_pkg holds:
  - EMPTY = -1.
  - Flag bit indices UNPLACED=0, OOB=1, MISMATCH=2.
  - State encoding, shared with the placer's state parameters for waveform consistency.
- One sub-module, placement_rd_port: issues a read on one memory, waits one cycle, captures the data, and returns a rd_done strobe. It is instantiated for the pos pair and for the grid.

Test Plan:
- GRID_N=6, NUM_NODES=4, nodes at (0,0),(1,2),(5,5),(3,0) with matching grid -> 4 records with flags 0; placed_cnt=4, occupied_cnt=4; no errors; done once.
- Node 2 left at (-1,-1), grid cell 35 empty -> node 2 record flags=3'b001; unplaced_cnt=1; placed_cnt=3; no errors.
- pos_X[1]=6 -> flags=3'b010; err_bounds=1; first_err_node=1.
- grid[8] holds 3 while node 1 is at (1,2) -> node 1 mismatch; err_mismatch=1; grid phase sets err_orphan at cell 8 (node 3 recorded at cell 18).
- out_ready low for 5 cycles on record 0 -> out_valid/out_node=0 held stable; no memory reads issued; resumes after ready.
- Assert reset during the grid phase -> outputs return to reset values next cycle; no done pulse; a new start completes normally.
